// File: rtl/rca_sweep_checker.sv
// rca_sweep_checker: exhaustive stimulus/response checker for a WIDTH-bit ripple-carry adder.
// Latency: each vector is held SETTLE cycles, then checked on the following edge.
//   A full sweep takes 2^(2*WIDTH)*(SETTLE+1) cycles from the start edge to done=1.
// Backpressure: none. start is honoured only in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   start             begin (or restart) a sweep
//   S, Cout           response from the adder under check
//   A, B              operands driven to the adder under check
//   busy, done, pass  sweep status; pass is meaningful only while done=1
//   err_count         number of mismatching vectors (sized so it cannot overflow)
//   fail_a, fail_b    operands of the first mismatching vector (0 if none)
//
// Optional build macro RCA_STOP_ON_FAIL_EN: when defined, the first mismatch ends the
// sweep immediately, with A/B frozen on the failing vector.

module rca_sweep_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   S,
  input  logic               Cout,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  // The settle counter needs at least one bit even when SETTLE=1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [2*WIDTH-1:0] VEC_ONE  = (2*WIDTH)'(1);
  localparam logic [2*WIDTH:0]   ERR_ONE  = (2*WIDTH+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH:0]   err_q, err_d;
  logic [WIDTH-1:0]   fail_a_q, fail_a_d;
  logic [WIDTH-1:0]   fail_b_q, fail_b_d;
  logic               first_q, first_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic [WIDTH:0]     golden;
  logic               mismatch;
  logic               last_vec;
  logic [2*WIDTH-1:0] vec_next;

  // Golden sum is WIDTH+1 bits so the carry is compared alongside the sum bits.
  assign golden   = {1'b0, a_q} + {1'b0, b_q};
  assign mismatch = (golden != {Cout, S});
  // {B,A} is one counter with A in the low half, so A varies fastest.
  assign last_vec = &{b_q, a_q};
  assign vec_next = {b_q, a_q} + VEC_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      first_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    first_d  = first_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;

    case (state_q)
      IDLE, DONE: begin
        // A restart from DONE behaves exactly like a start from IDLE;
        // otherwise every result is simply held.
        if (start) begin
          state_d  = WAIT;
          cnt_d    = '0;
          a_d      = '0;
          b_d      = '0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          first_d  = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
        end
      end

      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      CHECK: begin
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (!first_q) begin
            fail_a_d = a_q;
            fail_b_d = b_q;
            first_d  = 1'b1;
          end
        end
`ifdef RCA_STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
          // A/B are left on the vector just checked (the failing one, if any).
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d    = WAIT;
          {b_d, a_d} = vec_next;
        end
`else
        if (last_vec) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d    = WAIT;
          {b_d, a_d} = vec_next;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;

endmodule

// File: tb/tb_rca_sweep_checker.sv
module tb_rca_sweep_checker;

  localparam int W     = 4;
  localparam int SET   = 1;
  localparam int NV    = 1 << (2 * W);
  localparam int LIMIT = 4 * NV * (SET + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   s;
  logic           cout;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic           pass;
  logic [2*W:0]   err_count;
  logic [W-1:0]   fail_a;
  logic [W-1:0]   fail_b;

  int checks   = 0;
  int failures = 0;

  // Board adder: 0 good, 1 Cout stuck-at-0, 2 S[0] stuck-at-1, 3 bit stuck_bit stuck at stuck_val.
  int fault_mode = 0;
  int stuck_bit  = 0;
  int stuck_val  = 0;

  always #5 clk = ~clk;

  rca_sweep_checker #(.WIDTH(W), .SETTLE(SET)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .S         (s),
    .Cout      (cout),
    .A         (a),
    .B         (b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b)
  );

  function automatic logic [W:0] board_adder(input int mode, input int x, input int y,
                                             input int sb, input int sv);
    logic [W:0] r;
    r = (W+1)'(x + y);
    case (mode)
      1: r[W] = 1'b0;
      2: r[0] = 1'b1;
      3: r[sb] = sv[0];
      default: ;
    endcase
    return r;
  endfunction

  always_comb {cout, s} = board_adder(fault_mode, int'(a), int'(b), stuck_bit, stuck_val);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: walk every pair in sweep order, compare against plain A+B.
  task automatic ref_sweep(input int mode, output int errs, output int fa, output int fb,
                           output int nchk, output int la, output int lb);
    bit stopped;
    stopped = 1'b0;
    errs = 0; fa = 0; fb = 0; nchk = 0; la = 0; lb = 0;
    for (int vb = 0; vb < (1 << W); vb++) begin
      for (int va = 0; va < (1 << W); va++) begin
        if (!stopped) begin
          nchk++;
          la = va;
          lb = vb;
          if (board_adder(mode, va, vb, stuck_bit, stuck_val) != (W+1)'(va + vb)) begin
            errs++;
            if (errs == 1) begin
              fa = va;
              fb = vb;
            end
`ifdef RCA_STOP_ON_FAIL_EN
            stopped = 1'b1;
`endif
          end
        end
      end
    end
  endtask

  task automatic run_sweep(input int mode, input string tag, input bit stray);
    int errs, fa, fb, nchk, la, lb, cyc, idx;
    ref_sweep(mode, errs, fa, fb, nchk, la, lb);
    fault_mode = mode;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_done_after_start"}, 32'(done), 32'd0);
    chk({tag, "_err_after_start"},  32'(err_count), 32'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (stray && cyc == 49) begin
        @(negedge clk);
        start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
      if (mode == 0 && cyc == 100) begin
        idx = cyc / (SET + 1);
        chk({tag, "_mid_a"}, 32'(a), 32'(idx % (1 << W)));
        chk({tag, "_mid_b"}, 32'(b), 32'(idx / (1 << W)));
      end
    end
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(nchk * (SET + 1)));
    chk({tag, "_busy_end"},   32'(busy), 32'd0);
    chk({tag, "_pass"},       32'(pass), 32'(errs == 0));
    chk({tag, "_err_count"},  32'(err_count), 32'(errs));
    chk({tag, "_fail_a"},     32'(fail_a), 32'(fa));
    chk({tag, "_fail_b"},     32'(fail_b), 32'(fb));
    chk({tag, "_final_a"},    32'(a), 32'(la));
    chk({tag, "_final_b"},    32'(b), 32'(lb));
    // Results must hold while idle in DONE.
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_held"}, 32'(done), 32'd1);
    chk({tag, "_err_held"},  32'(err_count), 32'(errs));
  endtask

  task automatic reset_mid_sweep();
    fault_mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (99) begin
      @(posedge clk);
      #1;
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_a",      32'(a), 32'd0);
    chk("rst_b",      32'(b), 32'd0);
    chk("rst_err",    32'(err_count), 32'd0);
    chk("rst_fail_a", 32'(fail_a), 32'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_a",      32'(a), 32'd0);
    chk("reset_b",      32'(b), 32'd0);
    chk("reset_busy",   32'(busy), 32'd0);
    chk("reset_done",   32'(done), 32'd0);
    chk("reset_pass",   32'(pass), 32'd0);
    chk("reset_err",    32'(err_count), 32'd0);
    chk("reset_fail_a", 32'(fail_a), 32'd0);
    chk("reset_fail_b", 32'(fail_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_sweep(0, "good", 1'b0);
    run_sweep(1, "cout_sa0", 1'b0);
    run_sweep(2, "s0_sa1", 1'b0);
    run_sweep(0, "stray_start", 1'b1);
    reset_mid_sweep();
    run_sweep(0, "after_rst", 1'b0);
    for (int i = 0; i < 3; i++) begin
      stuck_bit = $urandom_range(0, W);
      stuck_val = $urandom_range(0, 1);
      run_sweep(3, "rand_stuck", 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
